// File: rtl/hoop_pkg.sv
`default_nettype none
// ============================================================================
// hoop_pkg: shared state encoding and field widths for the hoop game.
// Revision: 1.0
// ============================================================================
package hoop_pkg;

  localparam int SCORE_W = 8;
  localparam int TIME_W  = 8;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 8'd255;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READY  = 3'd1,
    PLAY   = 3'd2,
    COMMIT = 3'd3,
    OVER   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/hoop_game_ctrl_debounce.sv
`default_nettype none
// ============================================================================
// hoop_debounce: 2-flop synchronizer, stability counter, registered rise pulse.
// Revision: 1.0
// ============================================================================
module hoop_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      count <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      // Counter only advances while the synced input disagrees with the accepted level.
      if (sync2 == level) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        count <= '0;
        level <= sync2;
        rise  <= sync2;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hoop_game_ctrl.sv
`default_nettype none
// ============================================================================
// hoop_game_ctrl: round sequencer (countdown, timed play, basket count, leaderboard commit).
// Revision: 1.0
// ============================================================================
module hoop_game_ctrl
  import hoop_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int READY_SECS      = 3,
  parameter int ROUND_SECS      = 10,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               hoop_sw,
  input  logic [7:0]         user_id,
  output logic [TIME_W-1:0]  time_left,
  output logic [SCORE_W-1:0] score,
  output logic               playing,
  output logic               game_over,
  output logic               lb_req,
  output logic [SCORE_W-1:0] lb_score,
  output logic [7:0]         lb_id,
  input  logic               lb_ack
);

  localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_HZ - 1);
  localparam logic [TIME_W-1:0] READY_T  = TIME_W'(READY_SECS);
  localparam logic [TIME_W-1:0] ROUND_T  = TIME_W'(ROUND_SECS);

  state_t              state;
  state_t              state_next;
  logic                start_s1;
  logic                start_s2;
  logic                start_s3;
  logic                start_rise;
  logic                basket;
  logic [PRE_W-1:0]    prescale;
  logic                tick;
  logic [TIME_W-1:0]   time_next;
  logic [SCORE_W-1:0]  score_next;
  logic [7:0]          id_q;
  logic [7:0]          id_next;

  hoop_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_hoop_debounce (
    .clock(clock),
    .reset(reset),
    .raw  (hoop_sw),
    .rise (basket)
  );

  assign start_rise = start_s2 & ~start_s3;
  assign tick       = (prescale == PRE_LAST);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    time_next  = time_left;
    score_next = score;
    id_next    = id_q;
    unique case (state)
      IDLE, OVER: begin
        if (start_rise) begin
          state_next = READY;
          id_next    = user_id;
          score_next = '0;
          time_next  = READY_T;
        end
      end
      READY: begin
        if (tick) begin
          if (time_left == TIME_W'(1)) begin
            state_next = PLAY;
            time_next  = ROUND_T;
          end else begin
            time_next = time_left - 1'b1;
          end
        end
      end
      PLAY: begin
        // A basket on the final tick still lands before the score is handed off.
        if (basket && (score != SCORE_MAX)) begin
          score_next = score + 1'b1;
        end
        if (tick) begin
          if (time_left == TIME_W'(1)) begin
            state_next = COMMIT;
            time_next  = '0;
          end else begin
            time_next = time_left - 1'b1;
          end
        end
      end
      COMMIT: begin
        if (lb_ack) begin
          state_next = OVER;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      start_s1  <= 1'b0;
      start_s2  <= 1'b0;
      start_s3  <= 1'b0;
      prescale  <= '0;
      time_left <= '0;
      score     <= '0;
      id_q      <= '0;
      playing   <= 1'b0;
      game_over <= 1'b0;
      lb_req    <= 1'b0;
      lb_score  <= '0;
      lb_id     <= '0;
    end else begin
      start_s1  <= start;
      start_s2  <= start_s1;
      start_s3  <= start_s2;
      time_left <= time_next;
      score     <= score_next;
      id_q      <= id_next;
      // Phase lengths are exact because the prescaler restarts on every state entry.
      if ((state_next != state) || tick) begin
        prescale <= '0;
      end else begin
        prescale <= prescale + 1'b1;
      end
      playing   <= (state_next == PLAY);
      game_over <= (state_next == OVER);
      lb_req    <= (state_next == COMMIT);
      if ((state_next == COMMIT) && (state != COMMIT)) begin
        lb_score <= score_next;
        lb_id    <= id_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hoop_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboarded bench for hoop_game_ctrl: randomized rounds plus a saturation instance.
module tb_hoop_game_ctrl;

  localparam int CLK_HZ     = 10;
  localparam int READY_SECS = 2;
  localparam int ROUND_SECS = 3;
  localparam int DEB        = 4;
  localparam int READY_CYC  = READY_SECS * CLK_HZ;
  localparam int PLAY_CYC   = ROUND_SECS * CLK_HZ;
  localparam int LAT        = 2 + DEB + 1;
  localparam int SAT_ROUND  = 255;
  localparam int SAT_SHOTS  = 260;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, start, hoop_sw, lb_ack;
  logic [7:0] user_id, time_left, score, lb_score, lb_id;
  logic       playing, game_over, lb_req;

  logic       sat_reset, sat_start, sat_hoop, sat_ack;
  logic [7:0] sat_user, sat_time, sat_score, sat_lb_score, sat_lb_id;
  logic       sat_playing, sat_over, sat_req;

  hoop_game_ctrl #(.CLK_HZ(CLK_HZ), .READY_SECS(READY_SECS), .ROUND_SECS(ROUND_SECS),
                   .DEBOUNCE_CYCLES(DEB)) dut (
    .clock(clock), .reset(reset), .start(start), .hoop_sw(hoop_sw), .user_id(user_id),
    .time_left(time_left), .score(score), .playing(playing), .game_over(game_over),
    .lb_req(lb_req), .lb_score(lb_score), .lb_id(lb_id), .lb_ack(lb_ack));

  hoop_game_ctrl #(.CLK_HZ(CLK_HZ), .READY_SECS(READY_SECS), .ROUND_SECS(SAT_ROUND),
                   .DEBOUNCE_CYCLES(DEB)) dut_sat (
    .clock(clock), .reset(sat_reset), .start(sat_start), .hoop_sw(sat_hoop), .user_id(sat_user),
    .time_left(sat_time), .score(sat_score), .playing(sat_playing), .game_over(sat_over),
    .lb_req(sat_req), .lb_score(sat_lb_score), .lb_id(sat_lb_id), .lb_ack(sat_ack));

  typedef struct packed {
    logic [7:0] score;
    logic [7:0] id;
  } commit_t;

  commit_t exp_q[$];
  commit_t cur;
  logic    have_cur = 1'b0;
  logic    req_d    = 1'b0;
  int      play_len = 0;
  int      errors   = 0;
  int      checks   = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic int sat8(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  // Monitor: pops an expected commit whenever a new leaderboard request appears.
  initial begin
    forever begin
      @(negedge clock);
      if (playing === 1'b1) begin
        play_len++;
      end else if (play_len != 0) begin
        chk("play_window", play_len, PLAY_CYC);
        play_len = 0;
      end
      if (lb_req === 1'b1 && req_d !== 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          have_cur = 1'b0;
          $display("FAIL unexpected_req: got lb_req=1 expected no request at %0t", $time);
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
        end
      end
      if (lb_req === 1'b1 && have_cur) begin
        chk("lb_score", lb_score, cur.score);
        chk("lb_id", lb_id, cur.id);
      end
      req_d = lb_req;
    end
  end

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (lb_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cycles(1);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got lb_req=0 expected 1 within 80 cycles");
    end
  endtask

  task automatic do_start(input logic [7:0] uid);
    user_id = uid;
    start   = 1'b1;
    cycles(3);
    chk("ready_time", time_left, READY_SECS);
    chk("ready_score", score, 0);
    chk("ready_over", game_over, 0);
    start   = 1'b0;
    user_id = 8'($urandom);
  endtask

  // mode 0: random clean baskets, 1: bounce then hold, 2: basket on final tick, 3: reset in COMMIT
  task automatic run_round(input int mode, input logic [7:0] uid, input int force_k, input int ack_delay);
    int hs[$];
    int ls[$];
    int t, k, expn, h, l;
    bit ok;
    do_start(uid);
    hoop_sw = 1'b1;
    cycles(5);
    hoop_sw = 1'b0;
    cycles(READY_CYC - 6);
    chk("ready_basket_ignored", score, 0);
    chk("not_yet_playing", playing, 0);
    cycles(1);
    chk("play_entry", playing, 1);
    chk("play_time", time_left, ROUND_SECS);
    expn = 0;
    case (mode)
      0: begin
        t = 0;
        k = (force_k >= 0) ? force_k : int'($urandom_range(0, 3));
        for (int i = 0; i < k; i++) begin
          h = $urandom_range(4, 6);
          l = $urandom_range(4, 6);
          if (t + LAT <= PLAY_CYC) begin
            hs.push_back(h);
            ls.push_back(l);
            expn++;
            t += h + l;
          end
        end
        exp_q.push_back({8'(sat8(expn)), uid});
        for (int i = 0; i < hs.size(); i++) begin
          hoop_sw = 1'b1;
          cycles(hs[i]);
          hoop_sw = 1'b0;
          cycles(ls[i]);
        end
      end
      1: begin
        expn = 1;
        exp_q.push_back({8'd1, uid});
        for (int i = 0; i < 10; i++) begin
          hoop_sw = (i % 2 == 0);
          cycles(2);
        end
        hoop_sw = 1'b1;
      end
      2: begin
        expn = 1;
        exp_q.push_back({8'd1, uid});
        cycles(PLAY_CYC - LAT);
        hoop_sw = 1'b1;
        cycles(6);
        hoop_sw = 1'b0;
        chk("simul_score_before", score, 0);
        chk("simul_req_before", lb_req, 0);
        cycles(1);
        chk("simul_req_edge", lb_req, 1);
        chk("simul_playing_off", playing, 0);
      end
      default: begin
        exp_q.push_back({8'd0, uid});
      end
    endcase
    wait_req(ok);
    if (mode == 3) begin
      reset = 1'b0;
      cycles(1);
      chk("abort_req", lb_req, 0);
      chk("abort_score", score, 0);
      chk("abort_time", time_left, 0);
      chk("abort_over", game_over, 0);
      chk("abort_id", lb_id, 0);
      reset = 1'b1;
      cycles(2);
    end else if (ok) begin
      cycles(ack_delay);
      chk("req_before_ack", lb_req, 1);
      lb_ack = 1'b1;
      cycles(1);
      lb_ack = 1'b0;
      chk("req_dropped", lb_req, 0);
      chk("over_entry", game_over, 1);
      chk("final_score", score, sat8(expn));
      chk("final_time", time_left, 0);
      lb_ack = 1'b1;
      cycles(1);
      lb_ack = 1'b0;
      cycles(2);
      chk("score_hold", score, sat8(expn));
      chk("over_hold", game_over, 1);
    end
    hoop_sw = 1'b0;
    cycles(12);
  endtask

  task automatic run_sat();
    bit ok;
    sat_reset = 1'b1;
    cycles(2);
    sat_user  = 8'h5C;
    sat_start = 1'b1;
    cycles(3);
    sat_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (sat_playing === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cycles(1);
    end
    chk("sat_play_entry", int'(ok), 1);
    for (int i = 0; i < SAT_SHOTS; i++) begin
      sat_hoop = 1'b1;
      cycles(5);
      sat_hoop = 1'b0;
      cycles(4);
    end
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (sat_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cycles(1);
    end
    chk("sat_req_seen", int'(ok), 1);
    chk("sat_lb_score", sat_lb_score, sat8(SAT_SHOTS));
    chk("sat_lb_id", sat_lb_id, 8'h5C);
    chk("sat_score", sat_score, sat8(SAT_SHOTS));
    sat_ack = 1'b1;
    cycles(1);
    sat_ack = 1'b0;
    chk("sat_over", sat_over, 1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; hoop_sw = 1'b0; lb_ack = 1'b0; user_id = 8'h00;
    sat_reset = 1'b0; sat_start = 1'b0; sat_hoop = 1'b0; sat_ack = 1'b0; sat_user = 8'h00;
    cycles(2);
    lb_ack = 1'b1;
    cycles(3);
    lb_ack = 1'b0;
    chk("rst_time", time_left, 0);
    chk("rst_score", score, 0);
    chk("rst_playing", playing, 0);
    chk("rst_over", game_over, 0);
    chk("rst_req", lb_req, 0);
    chk("rst_lb_score", lb_score, 0);
    chk("rst_lb_id", lb_id, 0);
    reset = 1'b1;
    lb_ack = 1'b1;
    cycles(2);
    lb_ack = 1'b0;
    chk("idle_ack_ignored_over", game_over, 0);
    chk("idle_ack_ignored_req", lb_req, 0);
    run_round(0, 8'h2A, 3, 3);
    run_round(1, 8'($urandom), -1, $urandom_range(0, 3));
    run_round(2, 8'($urandom), -1, 0);
    run_round(3, 8'($urandom), -1, 0);
    for (int i = 0; i < 4; i++) begin
      run_round(0, 8'($urandom), -1, $urandom_range(0, 3));
    end
    run_round(1, 8'($urandom), -1, $urandom_range(0, 3));
    run_sat();
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got no completion expected finish before 2ms");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
